// File: rtl/ahb_apb_pkg.sv
// Shared types for the AHB-Lite to APB bridge: FSM states and AHB bus codes.
package ahb_apb_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  // AHB HTRANS encodings
  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  // AHB HRESP encodings
  typedef enum logic {
    HrespOkay  = 1'b0,
    HrespError = 1'b1
  } hresp_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not
  function automatic logic htrans_active(logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_apb_timeout.sv
// PREADY watchdog: counts ACCESS cycles without PREADY and flags expiry.
module ahb_apb_timeout #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] Limit   = TO_W'(TIMEOUT);
  localparam bit              Enabled = (TIMEOUT != 0);

  logic [TO_W-1:0] count_q;

  // Wait-cycle counter; clear takes priority over enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A zero limit disables the watchdog entirely
  always_comb begin
    expired_o = Enabled && (count_q == Limit);
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge with a PREADY timeout that turns a hung
// peripheral into a two-cycle AHB ERROR response.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  state_e      state_q, state_d;
  logic [31:0] paddr_q;
  logic        pwrite_q;
  logic [31:0] hrdata_q;
  logic        accept;
  logic        access_done;
  logic        to_clr;
  logic        to_en;
  logic        to_expired;

  // Every access is a full word and HTRANS[0] only separates NONSEQ from SEQ
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HTRANS[0]};

  assign accept      = (state_q == StIdle) && HSEL && htrans_active(HTRANS) && HREADY;
  assign access_done = (state_q == StAccess) && PREADY;

  // Counter only runs while waiting in ACCESS; any other state resets it
  assign to_clr = (state_q != StAccess);
  assign to_en  = (state_q == StAccess) && !PREADY;

  ahb_apb_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded bus outputs
  always_comb begin
    state_d   = state_q;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = HrespOkay;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSetup;
      end
      StSetup: begin
        PSEL      = 1'b1;
        HREADYOUT = 1'b0;
        state_d   = StAccess;
      end
      StAccess: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYOUT = 1'b0;
        // PREADY wins over a timeout firing in the same cycle
        if (PREADY) begin
          state_d = StIdle;
        end else if (to_expired) begin
          state_d = StErr1;
        end
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = HrespError;
        state_d   = StErr2;
      end
      StErr2: begin
        HRESP   = HrespError;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Address and direction captured at the AHB address phase, held otherwise
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      paddr_q  <= HADDR;
      pwrite_q <= HWRITE;
    end
  end

  // Read data latched on read completion; writes leave it untouched
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_q <= '0;
    end else if (access_done && !pwrite_q) begin
      hrdata_q <= PRDATA;
    end
  end

  // HWDATA is stable while HREADYOUT is low, so it can feed PWDATA directly
  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = HWDATA;
  assign HRDATA = hrdata_q;

endmodule
